// File: rtl/mult_arb_pkg.sv
// Shared constants and FSM encoding for the multiplier arbiter.
// Build option: MULT_ARB_TIMEOUT_EN enables the multiplier watchdog in mult_arbiter.
package mult_arb_pkg;

  localparam int WORD_W_DEF       = 256;
  localparam int PROD_W_DEF       = 2 * WORD_W_DEF;
  localparam int MULT_TIMEOUT_DEF = 300;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mult_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping at NREQ. Returns one-hot grant and its index.
module mult_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] idx
);

  // scan NREQ candidates starting at ptr; the first hit wins
  always_comb begin
    int  cand;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr) + i) % NREQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        idx       = IDXW'(cand);
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among NREQ requesters.
// Build option: define MULT_ARB_TIMEOUT_EN to abort jobs that see no mult_done
// within MULT_TIMEOUT cycles (ack with err=1 and a zero product).
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int WORD_W       = WORD_W_DEF,
  parameter int MULT_TIMEOUT = MULT_TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WORD_W-1:0]   req_a,
  input  logic [NREQ*WORD_W-1:0]   req_b,
  output logic [NREQ-1:0]          ack,
  output logic [2*WORD_W-1:0]      rsp_product,
  output logic                     err,
  output logic                     busy,
  output logic                     mult_start,
  output logic [WORD_W-1:0]        mult_a,
  output logic [WORD_W-1:0]        mult_b,
  input  logic                     mult_done,
  input  logic [2*WORD_W-1:0]      mult_product
);

  localparam int IDXW = $clog2(NREQ);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] ptr_q;
  logic [IDXW-1:0] gnt_idx_q;
  logic [NREQ-1:0] win_gnt;
  logic [IDXW-1:0] win_idx;
  logic            any_req;
  logic            timeout;

  mult_rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  assign any_req = |win_gnt;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MULT_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // done on the expiry cycle takes precedence over the timeout
  assign timeout = (state_q == ST_BUSY) && !mult_done &&
                   (cnt_q == CNT_W'(MULT_TIMEOUT - 1));

  // watchdog: cleared while issuing, counts BUSY cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt_q <= '0;
    else if (state_q == ST_ISSUE) cnt_q <= '0;
    else if (state_q == ST_BUSY)  cnt_q <= cnt_q + 1'b1;
  end

  // remember whether the current job was aborted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   err_q <= 1'b0;
    else if (state_q == ST_ISSUE) err_q <= 1'b0;
    else if (timeout)             err_q <= 1'b1;
  end

  assign err = (state_q == ST_RESP) && err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic; mult_done is only honoured in BUSY
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_BUSY;
      ST_BUSY:  if (mult_done || timeout) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // grant capture, product capture and pointer advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_idx_q   <= '0;
      ptr_q       <= '0;
      mult_a      <= '0;
      mult_b      <= '0;
      rsp_product <= '0;
    end else begin
      if (state_q == ST_IDLE && any_req) begin
        gnt_idx_q <= win_idx;
        mult_a    <= req_a[win_idx*WORD_W +: WORD_W];
        mult_b    <= req_b[win_idx*WORD_W +: WORD_W];
      end
      if (state_q == ST_BUSY && mult_done) rsp_product <= mult_product;
      else if (timeout)                    rsp_product <= '0;
      if (state_q == ST_RESP) begin
        if (gnt_idx_q == IDXW'(NREQ - 1)) ptr_q <= '0;
        else                              ptr_q <= gnt_idx_q + 1'b1;
      end
    end
  end

  // state-decoded outputs
  always_comb begin
    ack        = '0;
    busy       = (state_q != ST_IDLE);
    mult_start = (state_q == ST_ISSUE);
    if (state_q == ST_RESP) ack[gnt_idx_q] = 1'b1;
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter; the bench plays the role of the multiplier.
module tb_mult_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 256;
  localparam int PW   = 512;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0] ack;
  logic [PW-1:0]   rsp_product;
  logic            err;
  logic            busy;
  logic            mult_start;
  logic [W-1:0]    mult_a;
  logic [W-1:0]    mult_b;
  logic            mult_done = 1'b0;
  logic [PW-1:0]   mult_product = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.NREQ(NREQ), .WORD_W(W), .MULT_TIMEOUT(10)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .ack(ack), .rsp_product(rsp_product), .err(err), .busy(busy),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_done(mult_done), .mult_product(mult_product)
  );

  // stimulus: wait (bounded) for a mult_start pulse, sampled on falling edges
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mult_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // stimulus: multiplier answers lat cycles later; returns at the RESP cycle
  task automatic pulse_done(input int lat, input logic [PW-1:0] p);
    repeat (lat) @(negedge clk);
    mult_done    = 1'b1;
    mult_product = p;
    @(negedge clk);
    mult_done    = 1'b0;
    mult_product = '0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(negedge clk);
    tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL reset_ack: got %b want 0000", ack); end
    tests++; if ({err, busy, mult_start} !== 3'b000) begin fails++; $display("FAIL reset_ctrl: got %b want 000", {err, busy, mult_start}); end
    tests++; if (rsp_product !== '0 || mult_a !== '0 || mult_b !== '0) begin fails++; $display("FAIL reset_data: got rsp=%0h a=%0h b=%0h want 0", rsp_product, mult_a, mult_b); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req_a[2*W +: W] = 256'd3;
    req_b[2*W +: W] = 256'd5;
    req = 4'b0100;
    @(negedge clk);
    tests++; if (mult_start !== 1'b1) begin fails++; $display("FAIL single_start: got %b want 1", mult_start); end
    tests++; if (mult_a !== 256'd3 || mult_b !== 256'd5) begin fails++; $display("FAIL single_ops: got a=%0d b=%0d want 3 5", mult_a, mult_b); end
    @(negedge clk);
    tests++; if (mult_start !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL single_busy: got start=%b busy=%b want 0 1", mult_start, busy); end
    pulse_done(1, 512'd15);
    tests++; if (ack !== 4'b0100) begin fails++; $display("FAIL single_ack: got %b want 0100", ack); end
    tests++; if (rsp_product !== 512'd15) begin fails++; $display("FAIL single_prod: got %0d want 15", rsp_product); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL single_err: got %b want 0", err); end
    req = 4'b0000;
    @(negedge clk);
    tests++; if (ack !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL single_idle: got ack=%b busy=%b want 0000 0", ack, busy); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp;
    logic [3:0] exp_ack;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = W'(i + 1);
      req_b[i*W +: W] = 256'd10;
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = k % NREQ;
      exp_ack = 4'b0001 << exp;
      wait_start(ok);
      tests++; if (!ok) begin fails++; $display("FAIL rr_start_timeout: round %0d got no mult_start want one", k); end
      tests++; if (mult_a !== W'(exp + 1)) begin fails++; $display("FAIL rr_operand: round %0d got a=%0d want %0d", k, mult_a, exp + 1); end
      pulse_done(2, PW'((exp + 1) * 10));
      tests++; if (ack !== exp_ack) begin fails++; $display("FAIL rr_ack: round %0d got %b want %b", k, ack, exp_ack); end
      tests++; if (rsp_product !== PW'((exp + 1) * 10)) begin fails++; $display("FAIL rr_prod: round %0d got %0d want %0d", k, rsp_product, (exp + 1) * 10); end
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_max_operands();
    bit ok;
    logic [PW-1:0] big;
    big = '0;
    big = big - (512'd1 << 257) + 512'd1;
    req_a[3*W +: W] = '1;
    req_b[3*W +: W] = '1;
    req = 4'b1000;
    wait_start(ok);
    tests++; if (!ok) begin fails++; $display("FAIL max_start_timeout: got no mult_start want one"); end
    req_a[3*W +: W] = '0;
    req_b[3*W +: W] = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (mult_a !== {W{1'b1}} || mult_b !== {W{1'b1}}) begin fails++; $display("FAIL max_stable: cycle %0d got a=%0h b=%0h want all ones", i, mult_a, mult_b); end
    end
    pulse_done(1, big);
    tests++; if (ack !== 4'b1000) begin fails++; $display("FAIL max_ack: got %b want 1000", ack); end
    tests++; if (rsp_product !== big) begin fails++; $display("FAIL max_prod: got %0h want %0h", rsp_product, big); end
    tests++; if (mult_a !== {W{1'b1}}) begin fails++; $display("FAIL max_a_at_ack: got %0h want all ones", mult_a); end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    req_a[1*W +: W] = 256'd11;
    req_b[1*W +: W] = 256'd12;
    req = 4'b0010;
    wait_start(ok);
    @(negedge clk);
    tests++; if (!ok || busy !== 1'b1) begin fails++; $display("FAIL midrst_pre: got ok=%b busy=%b want 1 1", ok, busy); end
    rst_n = 1'b0;
    #1;
    tests++; if ({busy, mult_start, err} !== 3'b000 || ack !== 4'b0000) begin fails++; $display("FAIL midrst_ctrl: got busy=%b start=%b err=%b ack=%b want 0", busy, mult_start, err, ack); end
    tests++; if (rsp_product !== '0 || mult_a !== '0 || mult_b !== '0) begin fails++; $display("FAIL midrst_data: got rsp=%0h a=%0h b=%0h want 0", rsp_product, mult_a, mult_b); end
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    mult_done = 1'b1;
    mult_product = 512'd99;
    @(negedge clk);
    mult_done = 1'b0;
    tests++; if (ack !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL midrst_late_done: got ack=%b busy=%b want 0000 0", ack, busy); end
    @(negedge clk);
    tests++; if (ack !== 4'b0000 || rsp_product !== '0) begin fails++; $display("FAIL midrst_no_ack: got ack=%b rsp=%0d want 0000 0", ack, rsp_product); end
    req_a[1*W +: W] = 256'd7;
    req_b[1*W +: W] = 256'd6;
    req = 4'b0010;
    wait_start(ok);
    tests++; if (!ok || mult_a !== 256'd7) begin fails++; $display("FAIL midrst_next_issue: got ok=%b a=%0d want 1 7", ok, mult_a); end
    pulse_done(3, 512'd42);
    tests++; if (ack !== 4'b0010 || rsp_product !== 512'd42) begin fails++; $display("FAIL midrst_next_ack: got ack=%b rsp=%0d want 0010 42", ack, rsp_product); end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_spurious_done();
    mult_done = 1'b1;
    mult_product = 512'd555;
    @(negedge clk);
    mult_done = 1'b0;
    tests++; if (ack !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL spur_idle: got ack=%b busy=%b want 0000 0", ack, busy); end
    req_a[0 +: W] = 256'd9;
    req_b[0 +: W] = 256'd9;
    req = 4'b0001;
    @(negedge clk);
    tests++; if (mult_start !== 1'b1) begin fails++; $display("FAIL spur_start: got %b want 1", mult_start); end
    mult_done = 1'b1;
    mult_product = 512'd999;
    @(negedge clk);
    mult_done = 1'b0;
    tests++; if (ack !== 4'b0000 || busy !== 1'b1) begin fails++; $display("FAIL spur_issue: got ack=%b busy=%b want 0000 1", ack, busy); end
    @(negedge clk);
    tests++; if (ack !== 4'b0000 || busy !== 1'b1) begin fails++; $display("FAIL spur_still_busy: got ack=%b busy=%b want 0000 1", ack, busy); end
    pulse_done(1, 512'd81);
    tests++; if (ack !== 4'b0001 || rsp_product !== 512'd81) begin fails++; $display("FAIL spur_ack: got ack=%b rsp=%0d want 0001 81", ack, rsp_product); end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_drop_in_busy();
    bit ok;
    req_a[1*W +: W] = 256'd4;
    req_b[1*W +: W] = 256'd5;
    req = 4'b0010;
    wait_start(ok);
    @(negedge clk);
    req = 4'b0000;
    pulse_done(2, 512'd20);
    tests++; if (!ok || ack !== 4'b0010 || rsp_product !== 512'd20) begin fails++; $display("FAIL drop_ack: got ok=%b ack=%b rsp=%0d want 1 0010 20", ok, ack, rsp_product); end
    @(negedge clk);
    tests++; if (ack !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL drop_idle: got ack=%b busy=%b want 0000 0", ack, busy); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    req_a[0 +: W]   = 256'd2;
    req_b[0 +: W]   = 256'd10;
    req_a[2*W +: W] = 256'd3;
    req_b[2*W +: W] = 256'd10;
    req = 4'b0101;
    wait_start(ok);
    tests++; if (!ok || mult_a !== 256'd3) begin fails++; $display("FAIL b2b_first: got ok=%b a=%0d want 1 3", ok, mult_a); end
    pulse_done(1, 512'd30);
    tests++; if (ack !== 4'b0100) begin fails++; $display("FAIL b2b_ack1: got %b want 0100", ack); end
    req = 4'b0001;
    @(negedge clk);
    tests++; if (mult_start !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL b2b_gap: got start=%b busy=%b want 0 0", mult_start, busy); end
    @(negedge clk);
    tests++; if (mult_start !== 1'b1 || mult_a !== 256'd2) begin fails++; $display("FAIL b2b_second: got start=%b a=%0d want 1 2", mult_start, mult_a); end
    pulse_done(1, 512'd20);
    tests++; if (ack !== 4'b0001 || rsp_product !== 512'd20) begin fails++; $display("FAIL b2b_ack2: got ack=%b rsp=%0d want 0001 20", ack, rsp_product); end
    req = 4'b0000;
    @(negedge clk);
  endtask

`ifdef MULT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    req = 4'b0100;
    wait_start(ok);
    repeat (10) @(negedge clk);
    tests++; if (!ok || ack !== 4'b0000 || busy !== 1'b1) begin fails++; $display("FAIL to_early: got ok=%b ack=%b busy=%b want 1 0000 1", ok, ack, busy); end
    @(negedge clk);
    tests++; if (ack !== 4'b0100 || err !== 1'b1) begin fails++; $display("FAIL to_ack: got ack=%b err=%b want 0100 1", ack, err); end
    tests++; if (rsp_product !== '0) begin fails++; $display("FAIL to_prod: got %0d want 0", rsp_product); end
    req = 4'b0000;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_max_operands();
    test_reset_mid_job();
    test_spurious_done();
    test_drop_in_busy();
    test_back_to_back();
`ifdef MULT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
